// File: rtl/uart_parity_pkg.sv
// rtl/uart_parity_pkg.sv - parity type encodings, RX states and helper functions
package uart_parity_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int MIN_DATA_LEN = 5;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2
    } rx_state_t;

    // xor_all is the XOR of the data bits already restricted to the frame length.
    function automatic logic parity_of(input logic xor_all, input logic [1:0] typ);
        case (typ)
            PAR_EVEN: parity_of = xor_all;
            PAR_ODD:  parity_of = ~xor_all;
            PAR_MARK: parity_of = 1'b1;
            default:  parity_of = 1'b0;
        endcase
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        if (len < MIN_DATA_LEN) begin
            clamp_len = MIN_DATA_LEN;
        end else if (len > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/uart_parity_rx_check.sv
// rtl/uart_parity_rx_check.sv - serial RX parity accumulator, checker FSM and error counter
module uart_parity_rx_check
    import uart_parity_pkg::*;
#(
    parameter int LEN_W         = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     par_en,
    input  logic [1:0]               par_typ,
    input  logic [LEN_W-1:0]         data_len,
    input  logic                     rx_start,
    input  logic                     rx_bit,
    input  logic                     rx_bit_valid,
    input  logic                     err_cnt_clr,
    output logic                     par_done,
    output logic                     par_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    rx_state_t        state;
    logic             acc;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] frame_len;
    logic [1:0]       frame_typ;
    logic             frame_en;

    logic [LEN_W-1:0] bit_cnt_nxt;
    logic             last_data;
    logic             mismatch;

    assign bit_cnt_nxt = bit_cnt + LEN_W'(1);
    assign last_data   = (bit_cnt_nxt == frame_len);

    // Start has priority, so a parity bit arriving with Rx_Start is never checked.
    assign mismatch = !rx_start && rx_bit_valid && (state == RX_PARITY) &&
                      (rx_bit != parity_of(acc, frame_typ));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= RX_IDLE;
            acc       <= 1'b0;
            bit_cnt   <= '0;
            frame_len <= '0;
            frame_typ <= PAR_EVEN;
            frame_en  <= 1'b0;
            par_done  <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            par_done <= 1'b0;
            par_err  <= 1'b0;
            if (rx_start) begin
                state     <= RX_DATA;
                acc       <= 1'b0;
                bit_cnt   <= '0;
                frame_len <= data_len;
                frame_typ <= par_typ;
                frame_en  <= par_en;
            end else begin
                case (state)
                    RX_DATA: begin
                        if (rx_bit_valid) begin
                            acc     <= acc ^ rx_bit;
                            bit_cnt <= bit_cnt_nxt;
                            if (last_data) begin
                                if (frame_en) begin
                                    state <= RX_PARITY;
                                end else begin
                                    state    <= RX_IDLE;
                                    par_done <= 1'b1;
                                end
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_bit_valid) begin
                            state    <= RX_IDLE;
                            par_done <= 1'b1;
                            par_err  <= mismatch;
                        end
                    end
                    RX_IDLE: begin
                        state <= RX_IDLE;
                    end
                    default: begin
                        state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // Counts on the same edge that raises Par_Err, so both become visible together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (mismatch && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - UART TX parity generator and RX parity checker
module uart_parity_engine
    import uart_parity_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int LEN_W          = $clog2(MAX_DATA_WIDTH + 1),
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      PAR_EN,
    input  logic [1:0]                PAR_TYP,
    input  logic [LEN_W-1:0]          DATA_LEN,
    input  logic [MAX_DATA_WIDTH-1:0] P_DATA,
    input  logic                      Data_Valid,
    input  logic                      BUSY,
    output logic                      Par_Bit,
    output logic                      Par_Rdy,
    input  logic                      Rx_Start,
    input  logic                      Rx_Bit,
    input  logic                      Rx_Bit_Valid,
    output logic                      Par_Done,
    output logic                      Par_Err,
    output logic [ERR_CNT_WIDTH-1:0]  Err_Cnt,
    input  logic                      Err_Cnt_Clr
);

    logic [MAX_DATA_WIDTH-1:0] tx_data;
    logic                      load_pending;
    logic                      tx_load;
    logic                      tx_xor;
    logic [LEN_W-1:0]          len_clamped;

    assign tx_load     = Data_Valid && !BUSY;
    assign len_clamped = LEN_W'(clamp_len(int'(DATA_LEN), MAX_DATA_WIDTH));

    always_comb begin
        tx_xor = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < int'(len_clamped)) begin
                tx_xor = tx_xor ^ tx_data[i];
            end
        end
    end

    // Par_Bit tracks live config every enabled edge; Par_Rdy flags the first
    // edge at which it is computed from freshly loaded data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_data      <= '0;
            load_pending <= 1'b0;
            Par_Bit      <= 1'b0;
            Par_Rdy      <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_data <= P_DATA;
            end
            load_pending <= tx_load;
            Par_Rdy      <= load_pending && PAR_EN;
            if (PAR_EN) begin
                Par_Bit <= parity_of(tx_xor, PAR_TYP);
            end
        end
    end

    uart_parity_rx_check #(
        .LEN_W         (LEN_W),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_rx_check (
        .CLK          (CLK),
        .RST          (RST),
        .par_en       (PAR_EN),
        .par_typ      (PAR_TYP),
        .data_len     (len_clamped),
        .rx_start     (Rx_Start),
        .rx_bit       (Rx_Bit),
        .rx_bit_valid (Rx_Bit_Valid),
        .err_cnt_clr  (Err_Cnt_Clr),
        .par_done     (Par_Done),
        .par_err      (Par_Err),
        .err_cnt      (Err_Cnt)
    );

endmodule

// File: tb/tb_uart_parity_engine.sv
// tb/tb_uart_parity_engine.sv - self-checking bench for uart_parity_engine
module tb_uart_parity_engine;

    localparam int MAX_W   = 9;
    localparam int LEN_W   = 4;
    localparam int ECW     = 2;
    localparam int ERR_MAX = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             PAR_EN = 1'b0;
    logic [1:0]       PAR_TYP = 2'b00;
    logic [LEN_W-1:0] DATA_LEN = '0;
    logic [MAX_W-1:0] P_DATA = '0;
    logic             Data_Valid = 1'b0;
    logic             BUSY = 1'b0;
    logic             Par_Bit;
    logic             Par_Rdy;
    logic             Rx_Start = 1'b0;
    logic             Rx_Bit = 1'b0;
    logic             Rx_Bit_Valid = 1'b0;
    logic             Par_Done;
    logic             Par_Err;
    logic [ECW-1:0]   Err_Cnt;
    logic             Err_Cnt_Clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err_cnt = 0;

    typedef struct {
        string            name;
        logic [MAX_W-1:0] data;
        int               len;
        logic [1:0]       typ;
        logic             exp_bit;
    } tx_vec_t;

    tx_vec_t tx_tab[8];

    always #5 CLK = ~CLK;

    uart_parity_engine #(
        .MAX_DATA_WIDTH (MAX_W),
        .LEN_W          (LEN_W),
        .ERR_CNT_WIDTH  (ECW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .DATA_LEN     (DATA_LEN),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .BUSY         (BUSY),
        .Par_Bit      (Par_Bit),
        .Par_Rdy      (Par_Rdy),
        .Rx_Start     (Rx_Start),
        .Rx_Bit       (Rx_Bit),
        .Rx_Bit_Valid (Rx_Bit_Valid),
        .Par_Done     (Par_Done),
        .Par_Err      (Par_Err),
        .Err_Cnt      (Err_Cnt),
        .Err_Cnt_Clr  (Err_Cnt_Clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int ref_len(input int raw);
        if (raw < 5) return 5;
        if (raw > MAX_W) return MAX_W;
        return raw;
    endfunction

    function automatic logic ref_par(input logic [MAX_W-1:0] d, input int len, input logic [1:0] typ);
        int ones;
        ones = 0;
        for (int i = 0; i < len; i++) ones += int'(d[i]);
        case (typ)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'(1 - (ones % 2));
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= ERR_MAX) ? ERR_MAX : c + 1;
    endfunction

    task automatic set_vec(input int i, input string name, input logic [MAX_W-1:0] data,
                           input int len, input logic [1:0] typ, input logic exp_bit);
        tx_tab[i].name    = name;
        tx_tab[i].data    = data;
        tx_tab[i].len     = len;
        tx_tab[i].typ     = typ;
        tx_tab[i].exp_bit = exp_bit;
    endtask

    task automatic tx_load_check(input string name, input logic [MAX_W-1:0] data, input int len,
                                 input logic [1:0] typ, input logic exp_bit);
        P_DATA = data; DATA_LEN = LEN_W'(len); PAR_TYP = typ; PAR_EN = 1'b1;
        BUSY = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; P_DATA = ~data;
        chk({name, "_rdy_early"}, Par_Rdy, 0);
        tick();
        chk({name, "_bit"}, Par_Bit, exp_bit);
        chk({name, "_rdy"}, Par_Rdy, 1);
        tick();
        chk({name, "_rdy_once"}, Par_Rdy, 0);
        chk({name, "_bit_hold"}, Par_Bit, exp_bit);
    endtask

    task automatic rx_start_frame(input int len, input logic [1:0] typ, input logic en, input logic clr);
        DATA_LEN = LEN_W'(len); PAR_TYP = typ; PAR_EN = en;
        Rx_Start = 1'b1; Err_Cnt_Clr = clr;
        tick();
        Rx_Start = 1'b0; Err_Cnt_Clr = 1'b0;
        if (clr) exp_err_cnt = 0;
        chk("rx_start_done", Par_Done, 0);
    endtask

    task automatic rx_send(input string name, input logic b, input logic exp_done, input logic exp_err);
        Rx_Bit = b; Rx_Bit_Valid = 1'b1;
        tick();
        Rx_Bit_Valid = 1'b0; Rx_Bit = 1'($urandom);
        chk({name, "_done"}, Par_Done, exp_done);
        chk({name, "_err"}, Par_Err, exp_err);
    endtask

    task automatic rx_random_frame();
        int len_raw, len, gap;
        logic [1:0] typ;
        logic en, corrupt, clr, p;
        logic [MAX_W-1:0] d;
        len_raw = $urandom_range(0, 15);
        len     = ref_len(len_raw);
        typ     = 2'($urandom);
        en      = 1'($urandom);
        d       = MAX_W'($urandom);
        corrupt = ($urandom_range(0, 2) == 0);
        clr     = ($urandom_range(0, 3) == 0);
        rx_start_frame(len_raw, typ, en, clr);
        for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                DATA_LEN = LEN_W'($urandom); PAR_TYP = 2'($urandom); PAR_EN = 1'($urandom);
                tick();
                chk("rx_gap_done", Par_Done, 0);
            end
            rx_send("rx_rand_data", d[i], (i == len - 1) && !en, 1'b0);
        end
        if (en) begin
            p = ref_par(d, len, typ) ^ corrupt;
            if (corrupt) exp_err_cnt = sat_inc(exp_err_cnt);
            rx_send("rx_rand_par", p, 1'b1, corrupt);
        end
        chk("rx_rand_err_cnt", Err_Cnt, exp_err_cnt);
    endtask

    task automatic rx_bad_frame(input int exp_cnt);
        rx_start_frame(5, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) rx_send("sat_data", 1'b0, 1'b0, 1'b0);
        rx_send("sat_par", 1'b1, 1'b1, 1'b1);
        chk("sat_err_cnt", Err_Cnt, exp_cnt);
    endtask

    initial begin
        logic [6:0] bits7;
        logic [8:0] bits9;
        logic [MAX_W-1:0] rd;
        int rl;
        logic [1:0] rt;
        int sat_exp[5];

        bits7 = 7'b0001101;
        bits9 = 9'b101100111;
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

        set_vec(0, "tx_even_b3",   9'h0B3, 8,  2'b00, 1'b1);
        set_vec(1, "tx_odd_b3",    9'h0B3, 8,  2'b01, 1'b0);
        set_vec(2, "tx_mark_b3",   9'h0B3, 8,  2'b10, 1'b1);
        set_vec(3, "tx_space_b3",  9'h0B3, 8,  2'b11, 1'b0);
        set_vec(4, "tx_mask_1e0",  9'h1E0, 5,  2'b00, 1'b0);
        set_vec(5, "tx_len2_as_5", 9'h01F, 2,  2'b00, 1'b1);
        set_vec(6, "tx_len15_as9", 9'h1FF, 15, 2'b00, 1'b1);
        set_vec(7, "tx_odd_msb",   9'h100, 9,  2'b01, 1'b0);

        tick();
        tick();
        chk("reset_par_bit", Par_Bit, 0);
        chk("reset_par_rdy", Par_Rdy, 0);
        chk("reset_par_done", Par_Done, 0);
        chk("reset_par_err", Par_Err, 0);
        chk("reset_err_cnt", Err_Cnt, 0);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            tx_load_check(tx_tab[i].name, tx_tab[i].data, tx_tab[i].len, tx_tab[i].typ, tx_tab[i].exp_bit);
        end

        for (int i = 0; i < 30; i++) begin
            rd = MAX_W'($urandom);
            rl = $urandom_range(0, 15);
            rt = 2'($urandom);
            tx_load_check("tx_rand", rd, rl, rt, ref_par(rd, ref_len(rl), rt));
        end

        tx_load_check("tx_pre_busy", 9'h01F, 5, 2'b00, 1'b1);
        BUSY = 1'b1; Data_Valid = 1'b1; P_DATA = '0;
        tick();
        BUSY = 1'b0; Data_Valid = 1'b0;
        tick();
        chk("tx_busy_bit", Par_Bit, 1);
        chk("tx_busy_rdy", Par_Rdy, 0);

        P_DATA = '0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; PAR_EN = 1'b0;
        tick();
        chk("tx_en_off_rdy", Par_Rdy, 0);
        chk("tx_en_off_hold", Par_Bit, 1);
        PAR_EN = 1'b1;
        tick();
        chk("tx_en_on_bit", Par_Bit, 0);
        chk("tx_en_on_rdy", Par_Rdy, 0);

        rx_start_frame(7, 2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) rx_send("rx7_data", bits7[i], 1'b0, 1'b0);
        rx_send("rx7_par_ok", 1'b0, 1'b1, 1'b0);
        chk("rx7_cnt_ok", Err_Cnt, 0);
        tick();
        chk("rx7_done_once", Par_Done, 0);
        rx_start_frame(7, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) rx_send("rx7b_data", bits7[i], 1'b0, 1'b0);
        rx_send("rx7_par_bad", 1'b1, 1'b1, 1'b1);
        chk("rx7_cnt_bad", Err_Cnt, 1);
        exp_err_cnt = 1;

        rx_start_frame(9, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) rx_send("rx9_noen", bits9[i], (i == 8), 1'b0);
        rx_send("rx_idle_ignored", 1'b1, 1'b0, 1'b0);
        chk("rx9_cnt", Err_Cnt, 1);

        rx_start_frame(7, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) rx_send("rx_abort_data", 1'b1, 1'b0, 1'b0);
        rx_start_frame(7, 2'b00, 1'b1, 1'b0);
        DATA_LEN = LEN_W'(5); PAR_TYP = 2'b00; PAR_EN = 1'b1;
        Rx_Start = 1'b1; Rx_Bit_Valid = 1'b1; Rx_Bit = 1'b1;
        tick();
        Rx_Start = 1'b0; Rx_Bit_Valid = 1'b0;
        chk("rx_start_valid_done", Par_Done, 0);
        rx_send("rx_restart_d0", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) rx_send("rx_restart_data", 1'b0, 1'b0, 1'b0);
        rx_send("rx_restart_par", 1'b1, 1'b1, 1'b0);
        chk("rx_restart_cnt", Err_Cnt, 1);

        for (int i = 0; i < 40; i++) rx_random_frame();

        rx_start_frame(5, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) rx_send("sat_clr_data", 1'b0, 1'b0, 1'b0);
        rx_send("sat_clr_par", 1'b0, 1'b1, 1'b0);
        chk("sat_clr_cnt", Err_Cnt, 0);
        for (int i = 0; i < 5; i++) rx_bad_frame(sat_exp[i]);

        rx_start_frame(5, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) rx_send("clr_race_data", 1'b0, 1'b0, 1'b0);
        Err_Cnt_Clr = 1'b1;
        rx_send("clr_race_par", 1'b1, 1'b1, 1'b1);
        Err_Cnt_Clr = 1'b0;
        chk("clr_race_cnt", Err_Cnt, 0);

        rx_bad_frame(1);
        tx_load_check("pre_rst_tx", 9'h01F, 5, 2'b00, 1'b1);
        rx_start_frame(5, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) rx_send("pre_rst_data", 1'b1, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_par_bit", Par_Bit, 0);
        chk("midrst_par_rdy", Par_Rdy, 0);
        chk("midrst_par_done", Par_Done, 0);
        chk("midrst_par_err", Par_Err, 0);
        chk("midrst_err_cnt", Err_Cnt, 0);
        tick();
        RST = 1'b1;
        PAR_EN = 1'b1; PAR_TYP = 2'b00; DATA_LEN = LEN_W'(5);
        rx_send("post_rst_d3", 1'b1, 1'b0, 1'b0);
        rx_send("post_rst_d4", 1'b1, 1'b0, 1'b0);
        rx_send("post_rst_par", 1'b1, 1'b0, 1'b0);
        chk("post_rst_tx_bit", Par_Bit, 0);
        chk("post_rst_err_cnt", Err_Cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
